// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC scan sequencer.
package adc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StStart,
    StWait,
    StStore
  } seq_state_e;

  localparam int unsigned ADC_RES_W = 8;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// Loadable down-counter; expired_o pulses on the last counted cycle, then the count parks at zero.
module adc_seq_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired_o = (r_cnt == WIDTH'(1));

endmodule

// File: rtl/adc_sequencer.sv
// Multi-channel scan controller: mux select, settle, ADC start, capture on ready edge, stream out.
module adc_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned RESOLUTION  = ADC_RES_W,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned PERIOD_W    = 16,
  localparam int unsigned CH_W       = ch_idx_w(NUM_CH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  trigger_i,
  input  logic                  continuous_i,
  input  logic [PERIOD_W-1:0]   period_i,
  input  logic [NUM_CH-1:0]     ch_mask_i,
  input  logic                  clr_i,
  output logic [CH_W-1:0]       mux_sel_o,
  output logic                  adc_start_o,
  input  logic                  adc_rdy_i,
  input  logic [RESOLUTION-1:0] adc_result_i,
  output logic                  res_valid_o,
  output logic [CH_W-1:0]       res_ch_o,
  output logic [RESOLUTION-1:0] res_data_o,
  output logic                  scan_done_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic                  timeout_o
);

  localparam int unsigned TMR_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  seq_state_e r_state, w_state_d;

  logic [CH_W-1:0]       r_ch, w_first_ch, w_next_ch;
  logic [NUM_CH-1:0]     r_pending, w_rem;
  logic [RESOLUTION-1:0] r_data;
  logic                  r_skip, r_rdy_prev, r_ovr, r_tmo;

  logic                  w_busy, w_req, w_start, w_rdy_edge, w_valid;
  logic                  w_tmr_load, w_tmr_exp, w_per_load, w_per_exp;
  logic                  w_capture, w_timeout_set, w_advance, w_done;
  logic [TMR_W-1:0]      w_tmr_val;
  logic [PERIOD_W-1:0]   w_per_val;

  assign w_busy     = (r_state != StIdle);
  assign w_req      = trigger_i || (continuous_i && w_per_exp);
  assign w_start    = !w_busy && w_req && enable_i && (ch_mask_i != '0);
  assign w_rdy_edge = adc_rdy_i && !r_rdy_prev;
  // Remaining channels once the current one is retired.
  assign w_rem      = r_pending & ~(NUM_CH'(1) << r_ch);

  always_comb begin
    w_first_ch = '0;
    w_next_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask_i[i]) w_first_ch = CH_W'(i);
      if (w_rem[i])     w_next_ch  = CH_W'(i);
    end
  end

  // Period 0 would never expire; treat it as 1.
  assign w_per_val  = (period_i == '0) ? PERIOD_W'(1) : period_i;
  assign w_per_load = w_start || (continuous_i && w_per_exp);

  adc_seq_timer #(
    .WIDTH (PERIOD_W)
  ) u_period_tmr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_per_load),
    .load_val_i (w_per_val),
    .expired_o  (w_per_exp)
  );

  adc_seq_timer #(
    .WIDTH (TMR_W)
  ) u_step_tmr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .expired_o  (w_tmr_exp)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    w_capture     = 1'b0;
    w_timeout_set = 1'b0;
    w_advance     = 1'b0;
    w_done        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_d  = StSettle;
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(SETTLE_CYC);
        end
      end
      StSettle: begin
        if (w_tmr_exp) w_state_d = StStart;
      end
      StStart: begin
        w_state_d  = StWait;
        w_tmr_load = 1'b1;
        w_tmr_val  = TMR_W'(TIMEOUT_CYC);
      end
      StWait: begin
        if (w_rdy_edge) begin
          w_capture = 1'b1;
          w_state_d = StStore;
        end else if (w_tmr_exp) begin
          w_timeout_set = 1'b1;
          w_state_d     = StStore;
        end
      end
      StStore: begin
        if (!enable_i) begin
          w_state_d = StIdle;
        end else if (w_rem != '0) begin
          w_state_d  = StSettle;
          w_advance  = 1'b1;
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(SETTLE_CYC);
        end else begin
          w_done    = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ch       <= '0;
      r_pending  <= '0;
      r_data     <= '0;
      r_skip     <= 1'b0;
      r_rdy_prev <= 1'b0;
      r_ovr      <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_rdy_prev <= adc_rdy_i;
      if (w_start) begin
        r_pending <= ch_mask_i;
        r_ch      <= w_first_ch;
      end else if (w_advance) begin
        r_pending <= w_rem;
        r_ch      <= w_next_ch;
      end
      if (w_capture) begin
        r_data <= adc_result_i;
        r_skip <= 1'b0;
      end else if (w_timeout_set) begin
        r_skip <= 1'b1;
      end
      if (w_busy && w_req) r_ovr <= 1'b1;
      else if (clr_i)      r_ovr <= 1'b0;
      if (w_timeout_set)   r_tmo <= 1'b1;
      else if (clr_i)      r_tmo <= 1'b0;
    end
  end

  assign w_valid     = (r_state == StStore) && !r_skip;
  assign busy_o      = w_busy;
  assign adc_start_o = (r_state == StStart);
  assign mux_sel_o   = r_ch;
  assign res_valid_o = w_valid;
  assign res_ch_o    = w_valid ? r_ch : '0;
  assign res_data_o  = w_valid ? r_data : '0;
  assign scan_done_o = w_done;
  assign overrun_o   = r_ovr;
  assign timeout_o   = r_tmo;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer with a small behavioural ADC (3-cycle latency after start).
module tb_adc_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0, trigger_i = 1'b0, continuous_i = 1'b0, clr_i = 1'b0;
  logic [15:0] period_i = '0;
  logic [3:0]  ch_mask_i = '0;
  logic [1:0]  mux_sel_o, res_ch_o;
  logic        adc_start_o, res_valid_o, scan_done_o, busy_o, overrun_o, timeout_o;
  logic        adc_rdy = 1'b0;
  logic [7:0]  adc_result = '0, res_data_o;

  int checks = 0, errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_sequencer #(
    .RESOLUTION  (8),
    .NUM_CH      (4),
    .SETTLE_CYC  (4),
    .TIMEOUT_CYC (64),
    .PERIOD_W    (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .trigger_i    (trigger_i),
    .continuous_i (continuous_i),
    .period_i     (period_i),
    .ch_mask_i    (ch_mask_i),
    .clr_i        (clr_i),
    .mux_sel_o    (mux_sel_o),
    .adc_start_o  (adc_start_o),
    .adc_rdy_i    (adc_rdy),
    .adc_result_i (adc_result),
    .res_valid_o  (res_valid_o),
    .res_ch_o     (res_ch_o),
    .res_data_o   (res_data_o),
    .scan_done_o  (scan_done_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o),
    .timeout_o    (timeout_o)
  );

  // ADC model: ready rises 3 cycles after start, held 2 cycles; one channel can be made dead.
  logic [7:0] ch_data [4] = '{8'hA5, 8'h11, 8'h3C, 8'h77};
  int         cd = 0, hold = 0, edge_cyc = 0;
  logic [1:0] mch = '0;
  logic       dead_en = 1'b0;
  logic [1:0] dead_ch = 2'd1;

  always @(negedge clk) begin
    if (rst_i) begin
      cd = 0;
      hold = 0;
      adc_rdy = 1'b0;
    end else begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) adc_rdy = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          adc_rdy = 1'b1;
          adc_result = ch_data[mch];
          hold = 2;
          edge_cyc = cyc;
        end
      end
      if (adc_start_o && !(dead_en && mux_sel_o == dead_ch)) begin
        cd = 3;
        mch = mux_sel_o;
      end
    end
  end

  int   rec_ch [64], rec_data [64], rec_done [64], rec_cyc [64];
  int   scan_cyc [16];
  int   n_res = 0, n_done = 0, n_start = 0, n_scan = 0, start1_cyc = 0, tmo_cyc = 0;
  logic prev_busy = 1'b0, prev_tmo = 1'b0;

  always @(negedge clk) begin
    if (res_valid_o && n_res < 64) begin
      rec_ch[n_res]   = int'(res_ch_o);
      rec_data[n_res] = int'(res_data_o);
      rec_done[n_res] = int'(scan_done_o);
      rec_cyc[n_res]  = cyc;
      n_res++;
    end
    if (scan_done_o) n_done++;
    if (adc_start_o) begin
      n_start++;
      if (mux_sel_o == 2'd1) start1_cyc = cyc;
    end
    if (busy_o && !prev_busy && n_scan < 16) begin
      scan_cyc[n_scan] = cyc;
      n_scan++;
    end
    if (timeout_o && !prev_tmo) tmo_cyc = cyc;
    prev_busy = busy_o;
    prev_tmo  = timeout_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy_o && n < max_cyc) begin
      tick();
      n++;
    end
    chk("idle_within_bound", 32'(busy_o), 32'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, bs, bd, s;
    // Reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_start", 32'(adc_start_o), 0);
    chk("rst_mux", 32'(mux_sel_o), 0);
    chk("rst_outs", {res_valid_o, scan_done_o, overrun_o, timeout_o, res_ch_o, res_data_o}, 0);
    rst_i = 1'b0;
    tick();

    // Single scan, mask 0101
    enable_i  = 1'b1;
    ch_mask_i = 4'b0101;
    b = n_res;
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    chk("t1_busy_n1", 32'(busy_o), 1);
    chk("t1_mux_n1", 32'(mux_sel_o), 0);
    chk("t1_start_n1", 32'(adc_start_o), 0);
    repeat (3) tick();
    chk("t1_start_n4", 32'(adc_start_o), 0);
    tick();
    chk("t1_start_n5", 32'(adc_start_o), 1);
    tick();
    chk("t1_start_one_cycle", 32'(adc_start_o), 0);
    wait_idle(200);
    chk("t1_nres", n_res - b, 2);
    chk("t1_ch0", rec_ch[b], 0);
    chk("t1_d0", rec_data[b], 32'hA5);
    chk("t1_done0", rec_done[b], 0);
    chk("t1_ch1", rec_ch[b+1], 2);
    chk("t1_d1", rec_data[b+1], 32'h3C);
    chk("t1_done1", rec_done[b+1], 1);
    chk("t1_valid_after_edge", rec_cyc[b+1] - edge_cyc, 1);
    chk("t1_flags", {overrun_o, timeout_o}, 0);

    // Zero mask: trigger ignored
    ch_mask_i = 4'b0000;
    s = n_start;
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    chk("t2_busy", 32'(busy_o), 0);
    repeat (10) tick();
    chk("t2_no_start", n_start - s, 0);
    chk("t2_flags", {busy_o, overrun_o, timeout_o}, 0);

    // Continuous, period 200, all channels
    ch_mask_i    = 4'b1111;
    period_i     = 16'd200;
    continuous_i = 1'b1;
    bs = n_scan;
    b  = n_res;
    bd = n_done;
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    repeat (440) tick();
    continuous_i = 1'b0;
    wait_idle(100);
    chk("t3_scans", n_scan - bs, 3);
    chk("t3_period_a", scan_cyc[bs+1] - scan_cyc[bs], 200);
    chk("t3_period_b", scan_cyc[bs+2] - scan_cyc[bs+1], 200);
    chk("t3_strobes", n_res - b, 12);
    chk("t3_dones", n_done - bd, 3);
    chk("t3_overrun", 32'(overrun_o), 0);
    do_reset();

    // Continuous, period 20 shorter than the 36-cycle scan
    enable_i     = 1'b1;
    ch_mask_i    = 4'b1111;
    period_i     = 16'd20;
    continuous_i = 1'b1;
    bs = n_scan;
    b  = n_res;
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    repeat (25) tick();
    chk("t4_overrun_set", 32'(overrun_o), 1);
    clr_i     = 1'b1;
    trigger_i = 1'b1;
    tick();
    clr_i     = 1'b0;
    trigger_i = 1'b0;
    chk("t4_set_beats_clr", 32'(overrun_o), 1);
    continuous_i = 1'b0;
    wait_idle(100);
    chk("t4_one_scan", n_scan - bs, 1);
    chk("t4_strobes", n_res - b, 4);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("t4_overrun_clr", 32'(overrun_o), 0);

    // Dead channel 1: timeout, ch1 skipped
    dead_en = 1'b1;
    b  = n_res;
    bd = n_done;
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    wait_idle(300);
    dead_en = 1'b0;
    chk("t5_strobes", n_res - b, 3);
    chk("t5_ch_a", rec_ch[b], 0);
    chk("t5_ch_b", rec_ch[b+1], 2);
    chk("t5_d_b", rec_data[b+1], 32'h3C);
    chk("t5_ch_c", rec_ch[b+2], 3);
    chk("t5_d_c", rec_data[b+2], 32'h77);
    chk("t5_timeout", 32'(timeout_o), 1);
    // Start at s, 64 WAIT cycles, flag registered one cycle later.
    chk("t5_timeout_delay", tmo_cyc - start1_cyc, 65);
    chk("t5_done", n_done - bd, 1);

    // Reset during WAIT
    ch_mask_i = 4'b0001;
    b = n_res;
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    repeat (5) tick();
    chk("t6_busy_pre", 32'(busy_o), 1);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy_o), 0);
    chk("t6_rst_start", 32'(adc_start_o), 0);
    chk("t6_rst_outs", {res_valid_o, scan_done_o, overrun_o, timeout_o, mux_sel_o}, 0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    chk("t6_no_result", n_res - b, 0);
    ch_mask_i = 4'b0010;
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    wait_idle(100);
    chk("t6_nres", n_res - b, 1);
    chk("t6_ch", rec_ch[b], 1);
    chk("t6_data", rec_data[b], 32'h11);
    chk("t6_done", rec_done[b], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
